// File: rtl/alu_issue_queue.sv
// alu_issue_queue: command FIFO in front of an external combinational 32-bit ALU.
// The FIFO head drives the ALU; the ALU result is captured into a single-entry
// output register that is drained through a valid/ready handshake.
module alu_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [2:0]  cmd_op_i,
    input  logic [31:0] cmd_src1_i,
    input  logic [31:0] cmd_src2_i,
    output logic [31:0] alu_src1_o,
    output logic [31:0] alu_src2_o,
    output logic        alu_invertA_o,
    output logic        alu_invertB_o,
    output logic [1:0]  alu_operation_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_zero_i,
    input  logic        alu_overflow_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_data_o,
    output logic        res_zero_o,
    output logic        res_ovf_o,
    output logic        res_illegal_o,
    output logic [15:0] done_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] src1;
        logic [31:0] src2;
    } cmd_t;

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    state_t        state;

    logic full, empty, push, consume, issue;
    cmd_t head;
    logic dec_inv_a, dec_inv_b, dec_legal, dec_arith;
    logic [1:0] dec_oper;

    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    // Ready depends only on registered occupancy, so res_ready_i never reaches it.
    assign cmd_ready_o = !full;
    assign push        = cmd_valid_i && !full;
    assign res_valid_o = (state == S_FULL);
    assign consume     = res_valid_o && res_ready_i;
    assign issue       = !empty && (state == S_EMPTY || consume);
    assign head        = mem[rd_ptr];

    // Decode the head opcode into ALU controls; 011 is illegal and drives AND controls.
    always_comb begin
        dec_inv_a = 1'b0;
        dec_inv_b = 1'b0;
        dec_oper  = 2'b00;
        dec_legal = 1'b1;
        dec_arith = 1'b0;
        case (head.op)
            3'b000: dec_oper = 2'b00;
            3'b001: dec_oper = 2'b01;
            3'b010: begin dec_oper = 2'b10; dec_arith = 1'b1; end
            3'b110: begin dec_inv_b = 1'b1; dec_oper = 2'b10; dec_arith = 1'b1; end
            3'b111: begin dec_inv_b = 1'b1; dec_oper = 2'b11; end
            3'b100: begin dec_inv_a = 1'b1; dec_inv_b = 1'b1; dec_oper = 2'b00; end
            3'b101: begin dec_inv_a = 1'b1; dec_inv_b = 1'b1; dec_oper = 2'b01; end
            default: dec_legal = 1'b0;
        endcase
    end

    // An empty FIFO presents an all-zero command to the ALU.
    assign alu_src1_o      = empty ? 32'h0 : head.src1;
    assign alu_src2_o      = empty ? 32'h0 : head.src2;
    assign alu_invertA_o   = !empty && dec_inv_a;
    assign alu_invertB_o   = !empty && dec_inv_b;
    assign alu_operation_o = empty ? 2'b00 : dec_oper;

    // FIFO storage needs no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= '{op: cmd_op_i, src1: cmd_src1_i, src2: cmd_src2_i};
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + AW'(1);
            if (issue) rd_ptr <= rd_ptr + AW'(1);
            case ({push, issue})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Output register FSM: capture on issue, hold while the consumer stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= S_EMPTY;
            res_data_o    <= 32'h0;
            res_zero_o    <= 1'b0;
            res_ovf_o     <= 1'b0;
            res_illegal_o <= 1'b0;
            done_cnt_o    <= 16'h0;
        end else begin
            if (consume) done_cnt_o <= done_cnt_o + 16'h1;
            if (issue) begin
                res_data_o    <= dec_legal ? alu_result_i : 32'h0;
                res_zero_o    <= dec_legal ? alu_zero_i : 1'b1;
                res_ovf_o     <= dec_legal && dec_arith && alu_overflow_i;
                res_illegal_o <= !dec_legal;
            end
            case (state)
                S_EMPTY: if (issue) state <= S_FULL;
                S_FULL:  if (consume && !issue) state <= S_EMPTY;
                default: state <= S_EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: random and directed stimulus against an in-order scoreboard.
// The scoreboard computes results straight from opcode semantics; a small
// behavioural ALU stands in for the downstream datapath.
module tb_alu_issue_queue;
    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [2:0]  cmd_op_i;
    logic [31:0] cmd_src1_i, cmd_src2_i;
    logic [31:0] alu_src1_o, alu_src2_o;
    logic        alu_invertA_o, alu_invertB_o;
    logic [1:0]  alu_operation_o;
    logic [31:0] alu_result_i;
    logic        alu_zero_i, alu_overflow_i;
    logic        res_valid_o, res_ready_i;
    logic [31:0] res_data_o;
    logic        res_zero_o, res_ovf_o, res_illegal_o;
    logic [15:0] done_cnt_o;

    alu_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_src1_i(cmd_src1_i), .cmd_src2_i(cmd_src2_i),
        .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
        .alu_invertA_o(alu_invertA_o), .alu_invertB_o(alu_invertB_o),
        .alu_operation_o(alu_operation_o),
        .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i), .alu_overflow_i(alu_overflow_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_data_o(res_data_o), .res_zero_o(res_zero_o), .res_ovf_o(res_ovf_o),
        .res_illegal_o(res_illegal_o), .done_cnt_o(done_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Downstream ALU: optional operand inversion, carry-in tied to invertB.
    logic [31:0] sa, sb, ssum;
    logic        sovf;
    always_comb begin
        sa   = alu_invertA_o ? ~alu_src1_o : alu_src1_o;
        sb   = alu_invertB_o ? ~alu_src2_o : alu_src2_o;
        ssum = sa + sb + {31'h0, alu_invertB_o};
        sovf = (sa[31] == sb[31]) && (ssum[31] != sa[31]);
        case (alu_operation_o)
            2'b00:   alu_result_i = sa & sb;
            2'b01:   alu_result_i = sa | sb;
            2'b10:   alu_result_i = ssum;
            default: alu_result_i = {31'h0, ssum[31] ^ sovf};
        endcase
        alu_zero_i     = (alu_result_i == 32'h0);
        alu_overflow_i = sovf;
    end

    int          n_vec = 0;
    int          n_err = 0;
    logic [34:0] q[$];          // {illegal, ovf, zero, data} in push order
    logic [15:0] done_exp = 16'h0;
    int          lowrun = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected result straight from the opcode meaning.
    function automatic logic [34:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        logic        ovf, ill;
        d = 32'h0; ovf = 1'b0; ill = 1'b0;
        case (op)
            3'd0: d = a & b;
            3'd1: d = a | b;
            3'd2: begin d = a + b; ovf = (a[31] == b[31]) && (d[31] != a[31]); end
            3'd6: begin d = a - b; ovf = (a[31] != b[31]) && (d[31] != a[31]); end
            3'd7: d = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
            3'd4: d = ~(a | b);
            3'd5: d = ~(a & b);
            default: ill = 1'b1;
        endcase
        return {ill, ovf, (d == 32'h0), d};
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h7FFFFFFF;
            2: return 32'h80000000;
            3: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic rnd_cmd();
        cmd_op_i   = 3'($urandom_range(0, 7));
        cmd_src1_i = rnd_word();
        cmd_src2_i = rnd_word();
    endtask

    // One clock: note handshakes before the edge, update the model, then check.
    task automatic cycle();
        logic        psh, pop;
        logic [34:0] e;
        psh = cmd_valid_i && cmd_ready_o;
        pop = res_valid_o && res_ready_i;
        e   = ref_model(cmd_op_i, cmd_src1_i, cmd_src2_i);
        @(posedge clk_i);
        #1;
        if (rst_i) begin
            q.delete();
            done_exp = 16'h0;
        end else begin
            if (pop && q.size() > 0) begin
                void'(q.pop_front());
                done_exp = done_exp + 16'h1;
            end
            if (psh) q.push_back(e);
        end
        chk("done_cnt", {16'h0, done_cnt_o}, {16'h0, done_exp});
        chk("cmd_ready", {31'h0, cmd_ready_o}, {31'h0, (q.size() <= DEPTH)});
        if (q.size() == 0) begin
            chk("res_valid_idle", {31'h0, res_valid_o}, 32'h0);
            lowrun = 0;
        end else if (res_valid_o) begin
            chk("res_data", res_data_o, q[0][31:0]);
            chk("res_flags", {29'h0, res_illegal_o, res_ovf_o, res_zero_o}, {29'h0, q[0][34:32]});
            lowrun = 0;
        end else begin
            lowrun++;
            if (lowrun >= 2) chk("res_valid_stall", {31'h0, res_valid_o}, 32'h1);
        end
    endtask

    task automatic push_one(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        cmd_valid_i = 1'b1; cmd_op_i = op; cmd_src1_i = a; cmd_src2_i = b;
        cycle();
        cmd_valid_i = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [31:0] d, input logic [2:0] flags);
        int k;
        k = 0;
        while (!res_valid_o && k < 8) begin cycle(); k++; end
        chk({tag, "_valid"}, {31'h0, res_valid_o}, 32'h1);
        if (res_valid_o) begin
            chk({tag, "_data"}, res_data_o, d);
            chk({tag, "_flags"}, {29'h0, res_illegal_o, res_ovf_o, res_zero_o}, {29'h0, flags});
            res_ready_i = 1'b1;
            cycle();
            res_ready_i = 1'b0;
        end
    endtask

    initial begin
        int          acc, k;
        logic [31:0] snap;
        rst_i = 1'b1; cmd_valid_i = 1'b0; res_ready_i = 1'b0;
        cmd_op_i = 3'd0; cmd_src1_i = 32'h0; cmd_src2_i = 32'h0;
        cycle(); cycle();
        rst_i = 1'b0;
        chk("rst_res", {res_valid_o, res_zero_o, res_ovf_o, res_illegal_o, res_data_o[27:0]}, 32'h0);
        chk("rst_alu", alu_src1_o | alu_src2_o | {29'h0, alu_invertA_o, alu_operation_o}, 32'h0);
        chk("rst_ready", {31'h0, cmd_ready_o}, 32'h1);
        cycle();

        // ADD 5+3 with the consumer ready: valid two edges after the push.
        res_ready_i = 1'b1;
        push_one(3'd2, 32'd5, 32'd3);
        chk("add_lat1", {31'h0, res_valid_o}, 32'h0);
        cycle();
        chk("add_valid", {31'h0, res_valid_o}, 32'h1);
        chk("add_data", res_data_o, 32'h8);
        chk("add_flags", {30'h0, res_zero_o, res_ovf_o}, 32'h0);
        cycle();
        chk("add_done", {16'h0, done_cnt_o}, 32'h1);
        res_ready_i = 1'b0;

        push_one(3'd6, 32'h7FFFFFFF, 32'hFFFFFFFF);
        push_one(3'd7, 32'hFFFFFFFE, 32'h00000001);
        expect_res("sub", 32'h80000000, 3'b010);
        expect_res("slt", 32'h00000001, 3'b000);

        push_one(3'd3, $urandom, $urandom);
        push_one(3'd0, 32'hF0F0F0F0, 32'h0FF00FF0);
        expect_res("illegal", 32'h0, 3'b101);
        expect_res("and", 32'h00F000F0, 3'b000);

        // Fill with the consumer stalled: FIFO plus output register.
        cmd_valid_i = 1'b1; rnd_cmd();
        acc = 0;
        for (int i = 0; i < 12 && cmd_ready_o; i++) begin
            cycle(); acc++; rnd_cmd();
        end
        cmd_valid_i = 1'b0;
        chk("fill_count", acc, DEPTH + 1);
        chk("fill_ready", {31'h0, cmd_ready_o}, 32'h0);
        snap = res_data_o;
        cycle(); cycle(); cycle();
        chk("stall_stable", res_data_o, snap);
        res_ready_i = 1'b1;
        k = 0;
        while (q.size() > 0 && k < 20) begin cycle(); k++; end
        chk("drain_cycles", k, DEPTH + 1);
        chk("drain_idle", {31'h0, res_valid_o}, 32'h0);

        // Reset with work in flight discards everything.
        res_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin rnd_cmd(); push_one(cmd_op_i, cmd_src1_i, cmd_src2_i); end
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        chk("mid_rst_valid", {31'h0, res_valid_o}, 32'h0);
        chk("mid_rst_ready", {31'h0, cmd_ready_o}, 32'h1);
        chk("mid_rst_done", {16'h0, done_cnt_o}, 32'h0);
        chk("mid_rst_data", res_data_o, 32'h0);
        res_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) cycle();

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cmd_valid_i = ($urandom_range(0, 9) < 7);
            res_ready_i = ($urandom_range(0, 9) < 6);
            rst_i       = ($urandom_range(0, 499) == 0);
            rnd_cmd();
            cycle();
        end
        rst_i = 1'b1; cmd_valid_i = 1'b0;
        cycle();
        rst_i = 1'b0;

        // Continuous streaming until the consume counter wraps.
        cmd_valid_i = 1'b1; res_ready_i = 1'b1;
        k = 0;
        while (done_exp != 16'hFFFF && k < 70000) begin rnd_cmd(); cycle(); k++; end
        chk("wrap_ffff", {16'h0, done_cnt_o}, 32'h0000FFFF);
        k = 0;
        while (done_exp != 16'h0000 && k < 4) begin rnd_cmd(); cycle(); k++; end
        chk("wrap_zero", {16'h0, done_cnt_o}, 32'h0);
        cmd_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 Parameter: DEPTH, 4, command FIFO entries; SHALL be a power of two, at least 2.
REQ-002 Port: clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst_i  in  1  reset, synchronous, active-high.
REQ-004 Port: cmd_valid_i  in  1  command offered.
REQ-005 Port: cmd_ready_o  out  1  command accepted this cycle when high with cmd_valid_i.
REQ-006 Port: cmd_op_i  in  3  operation code, encoded per REQ-014.
REQ-007 Port: cmd_src1_i / cmd_src2_i  in  32 each  operands.
REQ-008 Port: alu_src1_o / alu_src2_o  out  32 each  operands driven to the downstream 32-bit ALU.
REQ-009 Port: alu_invertA_o, alu_invertB_o  out  1 each; alu_operation_o  out  2  ALU controls.
REQ-010 Port: alu_result_i  in  32; alu_zero_i, alu_overflow_i  in  1 each  ALU combinational outputs, same cycle.
REQ-011 Port: res_valid_o  out  1; res_ready_i  in  1  result handshake.
REQ-012 Port: res_data_o  out  32; res_zero_o, res_ovf_o, res_illegal_o  out  1 each  registered result and flags.
REQ-013 Port: done_cnt_o  out  16  count of results consumed (res_valid_o and res_ready_i both high), wraps 0xFFFF->0x0000.

Function
REQ-014 Op decode (op: invertA, invertB, operation): 000 AND 0,0,00; 001 OR 0,0,01; 010 ADD 0,0,10; 110 SUB 0,1,10; 111 SLT 0,1,11; 100 NOR 1,1,00; 101 NAND 1,1,01; 011 illegal, drives 0,0,00.
REQ-015 FIFO: push when cmd_valid_i and cmd_ready_o; cmd_ready_o = not full; full at DEPTH entries, no push when full, no overwrite.
REQ-016 ALU ports SHALL carry the FIFO head entry combinationally; when FIFO empty, all ALU outputs SHALL be 0.
REQ-017 Issue: head pops when FIFO non-empty and output register is EMPTY or being consumed this cycle; ALU result/flags captured into output register on the same edge; latency push-to-res_valid_o = 2 cycles minimum.
REQ-018 Output register FSM: EMPTY -> FULL on issue; FULL -> EMPTY on consume without issue; FULL -> FULL on consume with simultaneous issue (back-to-back, one result per cycle); FULL holds all res_* stable while res_ready_i low.
REQ-019 Simultaneous push and pop with FIFO full SHALL be allowed only as pop (cmd_ready_o low); push and pop with FIFO non-full SHALL keep occupancy constant.
REQ-020 Captured res_ovf_o = alu_overflow_i for ADD/SUB, else 0; res_zero_o = alu_zero_i.
REQ-021 Illegal op (011): captured res_data_o = 0x00000000, res_zero_o = 1, res_ovf_o = 0, res_illegal_o = 1; res_illegal_o = 0 for all legal ops.
REQ-022 Pointers SHALL wrap modulo DEPTH; occupancy counter SHALL be log2(DEPTH)+1 bits.
REQ-023 No combinational path from res_ready_i to cmd_ready_o.

Reset
REQ-024 While rst_i high at a clock edge: FIFO empty, pointers 0, FSM EMPTY, res_valid_o 0, res_data_o 0, res_zero_o 0, res_ovf_o 0, res_illegal_o 0, done_cnt_o 0; cmd_ready_o 1 the cycle after reset.
REQ-025 Reset asserted mid-operation SHALL discard all queued commands and any pending result; no result from before reset SHALL appear afterwards.

Verification
REQ-026 Push ADD 0x00000005, 0x00000003, res_ready_i=1 -> two cycles later res_valid_o=1, res_data_o=0x00000008, zero=0, ovf=0, done_cnt_o=1 next cycle.
REQ-027 Push SUB 0x7FFFFFFF, 0xFFFFFFFF -> res_data_o=0x80000000, res_ovf_o=1; push SLT 0xFFFFFFFE, 0x00000001 -> res_data_o=0x00000001.
REQ-028 res_ready_i=0, push DEPTH+1 commands -> cmd_ready_o drops after DEPTH+1 accepted (4 FIFO + 1 output register); res_* stable; raise res_ready_i -> results drain one per cycle in push order.
REQ-029 Push op 011 with any operands -> res_data_o=0x00000000, res_zero_o=1, res_illegal_o=1; following AND 0xF0F0F0F0, 0x0FF00FF0 -> 0x00F000F0, illegal=0.
REQ-030 Queue 3 commands with res_ready_i=0, assert rst_i one cycle -> res_valid_o=0, cmd_ready_o=1, done_cnt_o=0, no stale result after release.
REQ-031 Preload 0xFFFF consumes then one more -> done_cnt_o wraps to 0x0000.
